dbg_mem_host: RTL
=================

Name: dbg_mem_host

Overview:
- Debug-side initiator for the SoC debug memory port and halt line: mem_*_dbg, debug, mem_rdata_dbg.
- Consumes a byte-stream command channel (valid/ready, typically behind a UART receiver) and executes halt, resume, memory write and memory read.
- Returns ack, error or read-data bytes on a byte-stream response channel.
- Sits between the host link and the top-level debug inputs; used for program loading and memory inspection while the CPU is halted.

Parameters:
- RD_LATENCY, 1: cycles from mem_en_dbg assertion to valid mem_rdata_dbg (synchronous RAM).
- TIMEOUT_CYCLES, 1000000: inter-byte timeout; used only with DBG_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  command byte
- rx_valid  input  1  command byte valid
- rx_ready  output  1  block accepts rx_data this cycle
- tx_data  output  8  response byte
- tx_valid  output  1  response byte valid
- tx_ready  input  1  consumer accepts tx_data
- debug  output  1  CPU halt; also selects the debug memory path
- mem_en_dbg  output  1  memory enable
- mem_we_dbg  output  1  write enable
- mem_addr_dbg  output  32  byte address
- mem_wdata_dbg  output  32  write data
- mem_byte_sel_dbg  output  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- mem_rdata_dbg  input  32  read data
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0, including debug=0 and rx_ready=0; address, data and counter registers cleared. Reset mid-command abandons the command and releases halt. A partially sent response is dropped.
- Byte handshake: a transfer occurs when valid&&ready on a rising clk edge. tx_data and tx_valid are held stable until tx_ready. rx_ready=1 only in IDLE, ADDR and WDATA.
- Opcodes (first byte):
  - 0x01 HALT: debug<=1.
  - 0x02 RESUME: debug<=0.
  - 0x1s WRITE, size s=opcode[1:0].
  - 0x2s READ, size s=opcode[1:0].
  - Anything else, or s==3: respond 0xEE, return to IDLE.
- HALT and RESUME respond 0xA5. Repeated HALT while halted is legal and still responds 0xA5.
- WRITE and READ are followed by 4 address bytes, LSB first. WRITE then takes 4 data bytes, LSB first; the full 32-bit word drives mem_wdata_dbg and the RAM applies size/lanes.
- States:
  - IDLE: on opcode, go to ADDR (WRITE/READ) or RESP.
  - ADDR: count 0..3, shifting bytes into the address register; after byte 3, go to WDATA (write) or MEM (read).
  - WDATA: count 0..3; after byte 3, go to MEM.
  - MEM: exactly one cycle with mem_en_dbg=1, mem_we_dbg=write, addr/wdata/byte_sel driven. Write goes to RESP(0xA5); read goes to WAIT_RD.
  - WAIT_RD: wait RD_LATENCY cycles after the MEM cycle, capture mem_rdata_dbg, go to RESP with 4 bytes LSB first.
  - RESP: present bytes in order; after the last handshake, go to IDLE.
- mem_en_dbg and mem_we_dbg are 0 in every state except MEM. Address and data outputs hold their last value.
- Access while debug==0: WRITE/READ still consume all operand bytes. MEM is skipped (no mem_en_dbg pulse) and the response is 0xEE.
- Misalignment is not checked; the address is passed through unchanged.
- Byte counters are 2-bit and wrap to 0 on state exit.
- RESP with tx_ready held low: stall indefinitely; no rx bytes are accepted.

Optional Feature:
- Macro DBG_TIMEOUT_EN.
- With it: a counter runs in ADDR/WDATA and resets on each accepted rx byte. On reaching TIMEOUT_CYCLES, the block emits 0xEE and returns to IDLE. No memory access is made; debug is unchanged.
- Without it: ADDR/WDATA wait indefinitely; the counter logic is absent.

Decomposition:
- Package dbg_pkg holds:
  - opcode constants: OP_HALT, OP_RESUME, OP_WR, OP_RD;
  - response constants: RSP_ACK=8'hA5, RSP_ERR=8'hEE;
  - size encodings: SZ_B, SZ_H, SZ_W;
  - the FSM state enum.
- One natural sub-module: dbg_resp_ser, a 1–4 byte LSB-first response serializer with tx handshake.

Test Plan:
- 0x01 -> debug=1, tx 0xA5. Then 0x02 -> debug=0, tx 0xA5.
- HALT, then 0x12 with addr 00 01 00 00, data 78 56 34 12:
  - one-cycle mem_en_dbg=1, mem_we_dbg=1;
  - addr=0x00000100, wdata=0x12345678, byte_sel=10;
  - tx 0xA5.
- HALT, then 0x22 with addr 00 01 00 00; RAM returns 0x12345678 after RD_LATENCY -> tx 78,56,34,12 in order, with tx_ready toggled low between bytes.
- Not halted, 0x12 plus 8 operand bytes -> no mem_en_dbg pulse; tx 0xEE.
- Opcode 0x33 -> tx 0xEE, IDLE. Opcode 0x13 -> tx 0xEE.
- rst_n low during WDATA byte 2 with debug=1 -> all outputs 0, debug=0. After release, 0x01 -> 0xA5.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared opcode, response and size encodings plus the FSM state type for the
// debug memory host.
package dbg_pkg;

    localparam logic [7:0] OP_HALT   = 8'h01;
    localparam logic [7:0] OP_RESUME = 8'h02;
    localparam logic [7:0] OP_WR     = 8'h10;
    localparam logic [7:0] OP_RD     = 8'h20;

    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_MEM,
        ST_WAIT_RD,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dbg_resp_ser.sv
// 1-4 byte LSB-first response serializer driving a valid/ready byte stream.
module dbg_resp_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_len,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] data_q, data_d;
    logic [2:0]  rem_q, rem_d;
    logic        valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load && !valid_q) begin
            data_d  = load_data;
            rem_d   = load_len;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            if (rem_q == 3'd1) begin
                valid_d = 1'b0;
                rem_d   = 3'd0;
                done    = 1'b1;
            end else begin
                data_d = {8'h00, data_q[31:8]};
                rem_d  = rem_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = data_q[7:0];
    assign tx_valid = valid_q;

endmodule

// File: rtl/dbg_mem_host.sv
// Debug memory host: byte-stream command decoder driving halt and the debug
// memory port. Define DBG_TIMEOUT_EN to enable the inter-byte operand timeout.
module dbg_mem_host
    import dbg_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
`ifdef DBG_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        debug,
    output logic        mem_en_dbg,
    output logic        mem_we_dbg,
    output logic [31:0] mem_addr_dbg,
    output logic [31:0] mem_wdata_dbg,
    output logic [1:0]  mem_byte_sel_dbg,
    input  logic [31:0] mem_rdata_dbg,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        debug_q, debug_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_sel_q, mem_sel_d;
    logic [31:0] lat_q, lat_d;
    logic        live_q;

    logic        ser_load;
    logic [31:0] ser_data;
    logic [2:0]  ser_len;
    logic        ser_done;
    logic        rx_fire;
    logic        size_ok;

`ifdef DBG_TIMEOUT_EN
    logic [31:0] to_q, to_d;
`endif

    // rx_ready stays low for the first cycle after reset so every output reads 0 in reset.
    assign rx_ready = live_q && (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_WDATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign size_ok  = (rx_data[1:0] == SZ_B) || (rx_data[1:0] == SZ_H) || (rx_data[1:0] == SZ_W);

    always_comb begin
        state_d     = state_q;
        debug_d     = debug_q;
        is_wr_d     = is_wr_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        lat_d       = lat_q;
        ser_load    = 1'b0;
        ser_data    = '0;
        ser_len     = 3'd1;
        mem_en_dbg  = 1'b0;
        mem_we_dbg  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    cnt_d = '0;
                    if (rx_data == OP_HALT || rx_data == OP_RESUME) begin
                        debug_d  = (rx_data == OP_HALT);
                        ser_load = 1'b1;
                        ser_data = {24'h0, RSP_ACK};
                        state_d  = ST_RESP;
                    end else if (size_ok && ({rx_data[7:2], 2'b00} == OP_WR ||
                                             {rx_data[7:2], 2'b00} == OP_RD)) begin
                        is_wr_d = ({rx_data[7:2], 2'b00} == OP_WR);
                        size_d  = rx_data[1:0];
                        state_d = ST_ADDR;
                    end else begin
                        ser_load = 1'b1;
                        ser_data = {24'h0, RSP_ERR};
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    addr_d = {rx_data, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_WDATA;
                        end else if (debug_q) begin
                            mem_addr_d = addr_d;
                            mem_sel_d  = size_q;
                            state_d    = ST_MEM;
                        end else begin
                            ser_load = 1'b1;
                            ser_data = {24'h0, RSP_ERR};
                            state_d  = ST_RESP;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (rx_fire) begin
                    wdata_d = {rx_data, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (debug_q) begin
                            mem_addr_d  = addr_q;
                            mem_wdata_d = wdata_d;
                            mem_sel_d   = size_q;
                            state_d     = ST_MEM;
                        end else begin
                            ser_load = 1'b1;
                            ser_data = {24'h0, RSP_ERR};
                            state_d  = ST_RESP;
                        end
                    end
                end
            end
            ST_MEM: begin
                mem_en_dbg = 1'b1;
                mem_we_dbg = is_wr_q;
                if (is_wr_q) begin
                    ser_load = 1'b1;
                    ser_data = {24'h0, RSP_ACK};
                    state_d  = ST_RESP;
                end else begin
                    lat_d   = 32'd1;
                    state_d = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (lat_q >= RD_LATENCY) begin
                    ser_load = 1'b1;
                    ser_data = mem_rdata_dbg;
                    ser_len  = 3'd4;
                    state_d  = ST_RESP;
                end else begin
                    lat_d = lat_q + 32'd1;
                end
            end
            ST_RESP: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DBG_TIMEOUT_EN
        to_d = '0;
        if ((state_q == ST_ADDR || state_q == ST_WDATA) && !rx_fire) begin
            if (to_q >= TIMEOUT_CYCLES - 32'd1) begin
                cnt_d    = '0;
                ser_load = 1'b1;
                ser_data = {24'h0, RSP_ERR};
                state_d  = ST_RESP;
            end else begin
                to_d = to_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            debug_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            size_q      <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            lat_q       <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            debug_q     <= debug_d;
            is_wr_q     <= is_wr_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            lat_q       <= lat_d;
            live_q      <= 1'b1;
        end
    end

`ifdef DBG_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

    dbg_resp_ser u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_data (ser_data),
        .load_len  (ser_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done)
    );

    assign debug            = debug_q;
    assign mem_addr_dbg     = mem_addr_q;
    assign mem_wdata_dbg    = mem_wdata_q;
    assign mem_byte_sel_dbg = mem_sel_q;
    assign busy             = (state_q != ST_IDLE);

endmodule
